// File: rtl/alarm_responder.sv
// Alarm event controller: turns the alarm-match level into a beeping buzzer
// with snooze (bounded count), dismiss and an unattended-ring timeout.
module alarm_responder #(
  parameter int TICKS_PER_MS = 100000,
  parameter int BEEP_ON_MS   = 250,
  parameter int BEEP_OFF_MS  = 250,
  parameter int SNOOZE_S     = 300,
  parameter int TIMEOUT_S    = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       alrm_on,
  input  logic       alm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_cnt
);

  localparam int PRE_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MS_MAX  = (BEEP_ON_MS > BEEP_OFF_MS) ? BEEP_ON_MS : BEEP_OFF_MS;
  localparam int MS_W    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
  localparam int SEC_MAX = (SNOOZE_S > TIMEOUT_S) ? SNOOZE_S : TIMEOUT_S;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

  state_t           state_q, state_nx;
  logic             snz_q, dis_q;
  logic             snz_p, dis_p;
  logic [PRE_W-1:0] pre_q, pre_nx;
  logic [MS_W-1:0]  ms_q, ms_nx;
  logic             phase_q, phase_nx;
  logic [SEC_W-1:0] sec_q, sec_nx;
  logic [1:0]       cnt_nx;
  logic             ring_entry;

  assign snz_p = snooze & ~snz_q;
  assign dis_p = dismiss & ~dis_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nx = state_q;
    cnt_nx   = snooze_cnt;
    case (state_q)
      IDLE:   if (alrm_on && alm_en) state_nx = RING;
      RING: begin
        if (dis_p || !alm_en) begin
          state_nx = DONE;
        end else if (snz_p && (snooze_cnt < 2'(MAX_SNOOZE))) begin
          state_nx = SNOOZE;
          cnt_nx   = snooze_cnt + 2'd1;
        end else if (sec_tick && (sec_q == SEC_W'(TIMEOUT_S - 1))) begin
          state_nx = DONE;
        end
      end
      SNOOZE: begin
        if (dis_p || !alm_en)                                  state_nx = DONE;
        else if (sec_tick && (sec_q == SEC_W'(SNOOZE_S - 1)))  state_nx = RING;
      end
      DONE: begin
        if (!alrm_on) begin
          state_nx = IDLE;
          cnt_nx   = 2'd0;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Seconds counter is shared by RING and SNOOZE; a tick on the entry edge is dropped.
    sec_nx = sec_q;
    if (state_nx != state_q)                          sec_nx = '0;
    else if (sec_tick && (sec_q != SEC_W'(SEC_MAX - 1))) sec_nx = sec_q + SEC_W'(1);

    ring_entry = (state_nx == RING) && (state_q != RING);
    pre_nx     = pre_q;
    ms_nx      = ms_q;
    phase_nx   = phase_q;
    if (ring_entry) begin
      pre_nx   = '0;
      ms_nx    = '0;
      phase_nx = 1'b1;
    end else if (state_q == RING) begin
      if (pre_q == PRE_W'(TICKS_PER_MS - 1)) begin
        pre_nx = '0;
        if (ms_q == (phase_q ? MS_W'(BEEP_ON_MS - 1) : MS_W'(BEEP_OFF_MS - 1))) begin
          ms_nx    = '0;
          phase_nx = ~phase_q;
        end else begin
          ms_nx = ms_q + MS_W'(1);
        end
      end else begin
        pre_nx = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      snz_q      <= 1'b0;
      dis_q      <= 1'b0;
      pre_q      <= '0;
      ms_q       <= '0;
      phase_q    <= 1'b0;
      sec_q      <= '0;
      snooze_cnt <= 2'd0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
    end else begin
      state_q    <= state_nx;
      snz_q      <= snooze;
      dis_q      <= dismiss;
      pre_q      <= pre_nx;
      ms_q       <= ms_nx;
      phase_q    <= phase_nx;
      sec_q      <= sec_nx;
      snooze_cnt <= cnt_nx;
      // NOTE: outputs are flopped from next-state values, so they are glitch-free
      // yet still appear on the same edge as the state change.
      buzzer     <= (state_nx == RING) && phase_nx;
      ringing    <= (state_nx == RING);
      snoozed    <= (state_nx == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_responder.sv
// Scoreboard bench for alarm_responder: expected output vectors are queued as
// stimulus is applied and popped once the DUT has responded.
module tb_alarm_responder;

  localparam int TPM         = 4;
  localparam int ON_MS       = 2;
  localparam int OFF_MS      = 2;
  localparam int SNZ_S       = 3;
  localparam int TMO_S       = 5;
  localparam int MAX_SNZ     = 2;
  localparam int TICK_PERIOD = 50;
  localparam int ON_CYC      = ON_MS * TPM;
  localparam int OFF_CYC     = OFF_MS * TPM;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       alrm_on = 1'b0;
  logic       alm_en = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       buzzer, ringing, snoozed;
  logic [1:0] snooze_cnt;

  typedef struct {
    string      tag;
    logic [4:0] vec;   // {ringing, snoozed, buzzer, snooze_cnt}
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   tick_ph  = 0;
  int   waited;

  alarm_responder #(
    .TICKS_PER_MS(TPM), .BEEP_ON_MS(ON_MS), .BEEP_OFF_MS(OFF_MS),
    .SNOOZE_S(SNZ_S), .TIMEOUT_S(TMO_S), .MAX_SNOOZE(MAX_SNZ)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .alrm_on(alrm_on),
    .alm_en(alm_en), .snooze(snooze), .dismiss(dismiss), .buzzer(buzzer),
    .ringing(ringing), .snoozed(snoozed), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  // One-cycle sec_tick every TICK_PERIOD cycles, changed away from the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      tick_ph  = (tick_ph == TICK_PERIOD - 1) ? 0 : tick_ph + 1;
      sec_tick = (tick_ph == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic r, input logic s,
                            input logic b, input logic [1:0] c);
    exp_t e;
    e.tag = tag;
    e.vec = {r, s, b, c};
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    e = exp_q.pop_front();
    check(e.tag, 32'({ringing, snoozed, buzzer, snooze_cnt}), 32'(e.vec));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts sec_tick pulses sampled at clock edges; returns edges waited.
  task automatic wait_ticks(input int n, output int cycles);
    int seen = 0;
    cycles = 0;
    while (seen < n && cycles < (n + 1) * TICK_PERIOD) begin
      @(posedge clk);
      cycles++;
      if (sec_tick) seen++;
    end
    #1;
    if (seen < n) check("tick_wait_expired", 32'(seen), 32'(n));
  endtask

  function automatic logic beep_on(input int i);
    return (i % (ON_CYC + OFF_CYC)) < ON_CYC;
  endfunction

  initial begin
    // Reset state
    #3;
    expect_out("reset_state", 0, 0, 0, 2'd0);
    compare_out();
    #20;
    rst = 1'b1;
    cyc();

    // Basic ring and beep pattern
    alm_en  = 1'b1;
    alrm_on = 1'b1;
    expect_out("ring_entry", 1, 0, 1, 2'd0);
    cyc();
    compare_out();
    for (int i = 1; i < 2 * (ON_CYC + OFF_CYC); i++) begin
      expect_out($sformatf("beep_%0d", i), 1, 0, beep_on(i), 2'd0);
      cyc();
      compare_out();
    end
    dismiss = 1'b1;
    expect_out("dismiss", 0, 0, 0, 2'd0);
    cyc();
    compare_out();
    dismiss = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    expect_out("no_rering", 0, 0, 0, 2'd0);
    compare_out();
    alrm_on = 1'b0;
    cyc();
    cyc();

    // Snooze cycle with limit
    alrm_on = 1'b1;
    expect_out("ring2_entry", 1, 0, 1, 2'd0);
    cyc();
    compare_out();
    snooze = 1'b1;
    expect_out("snooze1", 0, 1, 0, 2'd1);
    cyc();
    compare_out();
    snooze = 1'b0;
    wait_ticks(SNZ_S - 1, waited);
    expect_out("snooze1_hold", 0, 1, 0, 2'd1);
    compare_out();
    snooze = 1'b1;
    expect_out("snooze_in_snooze", 0, 1, 0, 2'd1);
    cyc();
    compare_out();
    snooze = 1'b0;
    wait_ticks(1, waited);
    expect_out("resume1", 1, 0, 1, 2'd1);
    compare_out();
    snooze = 1'b1;
    expect_out("snooze2", 0, 1, 0, 2'd2);
    cyc();
    compare_out();
    snooze = 1'b0;
    wait_ticks(SNZ_S, waited);
    expect_out("resume2", 1, 0, 1, 2'd2);
    compare_out();
    snooze = 1'b1;
    expect_out("snooze_limit", 1, 0, 1, 2'd2);
    cyc();
    compare_out();
    snooze = 1'b0;
    expect_out("snooze_limit_ring", 1, 0, 1, 2'd2);
    cyc();
    compare_out();
    dismiss = 1'b1;
    expect_out("dismiss2", 0, 0, 0, 2'd2);
    cyc();
    compare_out();
    dismiss = 1'b0;
    alrm_on = 1'b0;
    cyc();
    cyc();

    // Unattended timeout
    alrm_on = 1'b1;
    expect_out("ring3_entry", 1, 0, 1, 2'd0);
    cyc();
    compare_out();
    wait_ticks(TMO_S - 1, waited);
    expect_out("before_timeout", 1, 0, beep_on(waited), 2'd0);
    compare_out();
    wait_ticks(1, waited);
    expect_out("timeout", 0, 0, 0, 2'd0);
    compare_out();
    alrm_on = 1'b0;
    cyc();
    cyc();

    // Dismiss beats snooze in the same cycle
    alrm_on = 1'b1;
    cyc();
    snooze  = 1'b1;
    dismiss = 1'b1;
    expect_out("dis_snz_same", 0, 0, 0, 2'd0);
    cyc();
    compare_out();
    snooze  = 1'b0;
    dismiss = 1'b0;
    alrm_on = 1'b0;
    cyc();
    cyc();

    // alm_en dropped while snoozed
    alrm_on = 1'b1;
    cyc();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    alm_en = 1'b0;
    expect_out("disarm_in_snooze", 0, 0, 0, 2'd1);
    cyc();
    compare_out();
    alrm_on = 1'b0;
    cyc();
    cyc();

    // Disabled alarm stays idle, re-arm rings during the matching minute
    alrm_on = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    expect_out("disabled_idle", 0, 0, 0, 2'd0);
    compare_out();
    alm_en = 1'b1;
    expect_out("rearm_ring", 1, 0, 1, 2'd0);
    cyc();
    compare_out();
    cyc();
    cyc();

    // Asynchronous reset mid-ring, then release during the match
    #3;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 0, 0, 0, 2'd0);
    compare_out();
    #2;
    rst = 1'b1;
    #1;
    expect_out("reset_release", 0, 0, 0, 2'd0);
    compare_out();
    expect_out("ring_after_reset", 1, 0, 1, 2'd0);
    cyc();
    compare_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alarm_responder.md
Name: alarm_responder

Overview:
- Consumes the registered alarm-match level `alrm_on` produced by the clock top and turns it into an audible, user-controlled alarm event.
- Drives a beeping buzzer output.
- Handles debounced snooze/dismiss buttons, a bounded number of snoozes and a ring timeout.
- Sits beside the time-keeping/compare logic in the alarm clock top, timed by the system clock plus the clock's 1 Hz tick.

Parameters:
- TICKS_PER_MS, 100000: clk cycles per internal 1 ms tick (100 MHz clk).
- BEEP_ON_MS, 250: buzzer high time per beep, in ms.
- BEEP_OFF_MS, 250: buzzer low time per beep, in ms.
- SNOOZE_S, 300: snooze duration, counted in sec_tick pulses.
- TIMEOUT_S, 60: maximum unattended ring duration, counted in sec_tick pulses.
- MAX_SNOOZE, 3: maximum snoozes per alarm event.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse once per second, from digital clock.
- alrm_on  in  1  level: current time equals alarm time; high for the whole matching minute.
- alm_en  in  1  alarm armed (switch level).
- snooze  in  1  debounced snooze button level.
- dismiss  in  1  debounced dismiss button level.
- buzzer  out  1  beep drive.
- ringing  out  1  high while in RING.
- snoozed  out  1  high while in SNOOZE.
- snooze_cnt  out  2  snoozes used in current event (width covers MAX_SNOOZE ≤ 3).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; all counters and edge-detect registers 0.
  - Reset mid-operation aborts the event immediately.
- Button handling:
  - snooze and dismiss pass through 1-cycle registered rising-edge detectors: `snz_p`, `dis_p`.
  - Only rising edges act. Holding a button has no further effect.
- FSM states: IDLE, RING, SNOOZE, DONE. All outputs are registered and change on the clk edge after the cause.
- IDLE:
  - alrm_on=1 && alm_en=1 → RING. Level-triggered, so a release from reset during the matching minute rings.
  - On entry, snooze_cnt=0.
- RING:
  - On entry: ms prescaler, beep counter and timeout counter cleared; beep phase=ON.
  - buzzer=1 in the first RING cycle.
  - Buzzer pattern: ON for BEEP_ON_MS*TICKS_PER_MS cycles, then OFF for BEEP_OFF_MS*TICKS_PER_MS cycles, repeating.
  - Transitions, in priority order:
    - (a) dis_p or alm_en=0 → DONE.
    - (b) snz_p and snooze_cnt<MAX_SNOOZE → SNOOZE, snooze_cnt+1.
    - (c) the TIMEOUT_S-th sec_tick since entry → DONE.
  - snz_p with snooze_cnt=MAX_SNOOZE is ignored; ringing continues.
  - Simultaneous dismiss+snooze: dismiss wins.
- SNOOZE:
  - buzzer=0. Snooze counter cleared on entry and counts sec_tick.
  - Transitions, in priority order:
    - dis_p or alm_en=0 → DONE.
    - The SNOOZE_S-th sec_tick → RING, independent of alrm_on.
  - snz_p in SNOOZE is ignored; no count extension.
- DONE:
  - buzzer=0. Waits for alrm_on=0, then → IDLE.
  - This prevents re-ringing in the same matching minute.
- Output decode:
  - ringing = (state==RING).
  - snoozed = (state==SNOOZE).
  - buzzer = RING && phase ON.
- Latency: from the alrm_on rise sampled at edge k, ringing=1 and buzzer=1 are visible after edge k (1 cycle).
- Width rules:
  - Counters are sized by $clog2 of their maxima.
  - Counters saturate or clear on state exit; no wrap-around inside a state.
  - sec_tick coinciding with a state entry is not counted.

Test Plan:
Bench parameters: TICKS_PER_MS=4, BEEP_ON_MS=2, BEEP_OFF_MS=2, SNOOZE_S=3, TIMEOUT_S=5, MAX_SNOOZE=2; sec_tick every 50 cycles.
- Basic ring: alm_en=1, raise alrm_on → ringing=1 next cycle; buzzer alternates 8 cycles high / 8 cycles low; dis_p → DONE, buzzer=0 next cycle; no re-ring while alrm_on=1; alrm_on=0 → IDLE.
- Snooze cycle: ring, pulse snooze → snoozed=1, snooze_cnt=1, buzzer=0; after 3 sec_ticks → ringing=1, buzzer high first cycle; snooze again → snooze_cnt=2; third snooze press ignored, ringing stays 1.
- Timeout: ring with no input → after the 5th sec_tick, state=DONE, buzzer=0, ringing=0.
- Priority: snooze and dismiss rising in the same cycle during RING → DONE, snooze_cnt unchanged; alm_en dropped during SNOOZE → DONE.
- Disabled/re-arm: alm_en=0 with alrm_on=1 → stays IDLE, buzzer=0; alm_en→1 while alrm_on still 1 → RING next cycle.
- Async reset: assert rst=0 mid-RING between clk edges → buzzer, ringing, snoozed and snooze_cnt all 0 immediately; release with alrm_on=1, alm_en=1 → RING one cycle after the first edge.
